// File: rtl/bnn_pkg.sv
// Shared sizing constants for the binarised neural-network datapath.
package bnn_pkg;

  localparam int unsigned ACC_W      = 18;
  localparam int unsigned LAST_LAYER = 3;
  localparam int unsigned RF_DEPTH   = 128;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned PIX_W      = 9;
  localparam int unsigned LAYER_W    = 3;
  localparam int unsigned CLASS_W    = 4;

endpackage

// File: rtl/bnn_rf.sv
// 1-bit activation register file: synchronous write, registered read, synchronous clear.
module bnn_rf
  import bnn_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);

  logic [DEPTH-1:0] mem;

  // Read samples the pre-edge contents, so a same-address write/read returns the old bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      rdata <= 1'b0;
    end else begin
      if (wen) mem[waddr] <= wdata;
      if (ren) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bnn_datapath.sv
// BNN MAC datapath: binarised accumulate, activation register file and output-layer argmax.
module bnn_datapath
  import bnn_pkg::ADDR_W, bnn_pkg::PIX_W, bnn_pkg::LAYER_W, bnn_pkg::CLASS_W;
#(
  parameter int unsigned ACC_W      = bnn_pkg::ACC_W,
  parameter int unsigned LAST_LAYER = bnn_pkg::LAST_LAYER,
  parameter int unsigned RF_DEPTH   = bnn_pkg::RF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LAYER_W-1:0]       layer,
  input  logic                     cu_rst,
  input  logic                     g_reg_rst7,
  input  logic                     rf_wen,
  input  logic                     rf_ren,
  input  logic [ADDR_W-1:0]        rf_waddr,
  input  logic [ADDR_W-1:0]        rf_raddr,
  input  logic                     wmem_data,
  input  logic [PIX_W-1:0]         dmem_data,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     rf_rdata,
  output logic [CLASS_W-1:0]       pred_class,
  output logic signed [ACC_W-1:0]  max_acc,
  output logic                     pred_valid
);

  logic                    acc_en;
  logic                    rf_we;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] term;
  logic                    take_candidate;

  assign pix_ext = ACC_W'($signed(dmem_data));
  assign rf_we   = rf_wen && (layer != LAYER_W'(LAST_LAYER));

  always_comb begin
    term = '0;
    if (layer == '0) term = wmem_data ? pix_ext : -pix_ext;
    else             term = (wmem_data ~^ rf_rdata) ? ACC_W'(1) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_en <= 1'b0;
    else     acc_en <= rf_ren;
  end

  // cu_rst seeds with the in-flight term so consecutive neurons need no idle cycle.
  always_ff @(posedge clk) begin
    if (rst)         acc <= '0;
    else if (cu_rst) acc <= acc_en ? term : '0;
    else if (acc_en) acc <= acc + term;
  end

  bnn_rf #(
    .DEPTH (RF_DEPTH)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .wen   (rf_we),
    .waddr (rf_waddr),
    .wdata (~acc[ACC_W-1]),
    .ren   (rf_ren),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // A commit coinciding with g_reg_rst7 is taken as the first candidate.
  assign take_candidate = rf_wen && (g_reg_rst7 || !pred_valid || (acc > max_acc));

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_class <= '0;
      max_acc    <= '0;
    end else if (take_candidate) begin
      pred_valid <= 1'b1;
      pred_class <= rf_waddr[CLASS_W-1:0];
      max_acc    <= acc;
    end else if (g_reg_rst7) begin
      pred_valid <= 1'b0;
      pred_class <= '0;
      max_acc    <= '0;
    end
  end

endmodule

// File: tb/tb_bnn_datapath.sv
// Randomised and directed bench for bnn_datapath against an integer reference model.
module tb_bnn_datapath;

  localparam int unsigned ACC_W = 18;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [2:0]              layer = '0;
  logic                    cu_rst = 1'b0;
  logic                    g_reg_rst7 = 1'b0;
  logic                    rf_wen = 1'b0;
  logic                    rf_ren = 1'b0;
  logic [6:0]              rf_waddr = '0;
  logic [6:0]              rf_raddr = '0;
  logic                    wmem_data = 1'b0;
  logic [8:0]              dmem_data = '0;
  logic signed [ACC_W-1:0] acc;
  logic                    rf_rdata;
  logic [3:0]              pred_class;
  logic signed [ACC_W-1:0] max_acc;
  logic                    pred_valid;

  int n_checks = 0;
  int n_fail   = 0;

  bnn_datapath #(
    .ACC_W      (ACC_W),
    .LAST_LAYER (3),
    .RF_DEPTH   (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .layer      (layer),
    .cu_rst     (cu_rst),
    .g_reg_rst7 (g_reg_rst7),
    .rf_wen     (rf_wen),
    .rf_ren     (rf_ren),
    .rf_waddr   (rf_waddr),
    .rf_raddr   (rf_raddr),
    .wmem_data  (wmem_data),
    .dmem_data  (dmem_data),
    .acc        (acc),
    .rf_rdata   (rf_rdata),
    .pred_class (pred_class),
    .max_acc    (max_acc),
    .pred_valid (pred_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, one update per rising edge.
  bit m_live = 1'b0;
  int m_acc, m_mx, m_pc;
  bit m_en, m_rd, m_pv;
  bit m_rf [128];

  always @(posedge clk) begin
    int term, nacc;
    if (rst) begin
      m_acc = 0; m_mx = 0; m_pc = 0;
      m_en = 0; m_rd = 0; m_pv = 0;
      m_rf = '{default: 1'b0};
      m_live = 1'b1;
    end else begin
      if (layer == 0) term = wmem_data ? int'($signed(dmem_data)) : -int'($signed(dmem_data));
      else            term = (wmem_data == m_rd) ? 1 : -1;
      if (cu_rst) nacc = m_en ? term : 0;
      else        nacc = m_en ? m_acc + term : m_acc;
      if (rf_wen && (g_reg_rst7 || !m_pv || m_acc > m_mx)) begin
        m_mx = m_acc; m_pc = int'(rf_waddr) % 16; m_pv = 1'b1;
      end else if (g_reg_rst7) begin
        m_mx = 0; m_pc = 0; m_pv = 1'b0;
      end
      if (rf_ren) m_rd = m_rf[rf_raddr];
      if (rf_wen && layer != 3) m_rf[rf_waddr] = (m_acc >= 0);
      m_acc = nacc;
      m_en  = rf_ren;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("acc", int'(acc), m_acc);
      chk("rf_rdata", int'(rf_rdata), int'(m_rd));
      chk("pred_class", int'(pred_class), m_pc);
      chk("max_acc", int'(max_acc), m_mx);
      chk("pred_valid", int'(pred_valid), int'(m_pv));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; cu_rst = 0; g_reg_rst7 = 0; rf_wen = 0; rf_ren = 0;
    wmem_data = 0; dmem_data = '0;
  endtask

  task automatic mac(input int ra, input bit w, input int d);
    idle(); rf_ren = 1; rf_raddr = 7'(ra); wmem_data = w; dmem_data = 9'(d); step();
  endtask

  task automatic dat(input bit w, input int d);
    idle(); wmem_data = w; dmem_data = 9'(d); step();
  endtask

  task automatic clr();
    idle(); cu_rst = 1; step();
  endtask

  task automatic commit(input int wa);
    idle(); rf_wen = 1; rf_waddr = 7'(wa); step();
  endtask

  task automatic load_acc(input int v);
    layer = 3'd0; clr(); mac(0, 0, 0); dat(1, v);
  endtask

  initial begin
    int vals [4] = '{5, 7, 7, -2};

    idle(); rst = 1; step(); idle();
    chk("rst_acc", int'(acc), 0);
    chk("rst_rdata", int'(rf_rdata), 0);
    chk("rst_pred_valid", int'(pred_valid), 0);

    // Layer-0 pixel MAC: +10 +5 -100.
    layer = 3'd0; clr(); mac(0, 0, 0); mac(1, 1, 10); mac(2, 0, -5); dat(0, 100);
    chk("l0_acc", int'(acc), -85);
    chk("l0_model", m_acc, -85);

    // Seed rf[0..3] = 1,0,1,1, then a layer-1 XNOR neuron.
    commit(1); load_acc(0); commit(0); commit(2); commit(3);
    layer = 3'd1; clr(); mac(0, 0, 0); mac(1, 1, 0); mac(2, 1, 0); mac(3, 0, 0);
    chk("l1_partial_acc", int'(acc), -1);
    dat(1, 0);
    chk("l1_acc", int'(acc), 0);
    chk("l1_model", m_acc, 0);
    commit(9);
    mac(9, 0, 0);
    chk("rf9_zero_is_nonneg", int'(rf_rdata), 1);

    // cu_rst with an in-flight +1 term.
    mac(9, 1, 0);
    chk("pre_curst_acc", int'(acc), 1);
    idle(); cu_rst = 1; wmem_data = 1; step();
    chk("curst_term_acc", int'(acc), 1);

    // Output-layer argmax, ties keep the lower index.
    idle(); g_reg_rst7 = 1; step();
    chk("argmax_clear_valid", int'(pred_valid), 0);
    for (int i = 0; i < 4; i++) begin
      load_acc(vals[i]); layer = 3'd3; commit(i);
    end
    chk("argmax_class", int'(pred_class), 1);
    chk("argmax_max", int'(max_acc), 7);
    chk("argmax_valid", int'(pred_valid), 1);
    chk("argmax_model_class", m_pc, 1);
    layer = 3'd1; mac(1, 0, 0);
    chk("last_layer_no_write_1", int'(rf_rdata), 0);
    mac(3, 0, 0);
    chk("last_layer_no_write_3", int'(rf_rdata), 1);

    // Same-address write and read returns the old bit.
    load_acc(3); layer = 3'd1;
    idle(); rf_wen = 1; rf_waddr = 7'd1; rf_ren = 1; rf_raddr = 7'd1; step();
    chk("wr_rd_collide_old", int'(rf_rdata), 0);
    mac(1, 0, 0);
    chk("wr_rd_collide_new", int'(rf_rdata), 1);

    // Reset mid-MAC clears everything and drops the pending accumulate.
    layer = 3'd0; clr(); mac(0, 0, 0); mac(0, 1, 50);
    chk("pre_rst_acc", int'(acc), 50);
    idle(); rst = 1; rf_ren = 1; wmem_data = 1; dmem_data = 9'd50; step();
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_rdata", int'(rf_rdata), 0);
    chk("midrst_class", int'(pred_class), 0);
    chk("midrst_max", int'(max_acc), 0);
    chk("midrst_valid", int'(pred_valid), 0);
    dat(1, 77);
    chk("midrst_no_pending", int'(acc), 0);
    mac(9, 0, 0);
    chk("midrst_rf9", int'(rf_rdata), 0);
    mac(1, 0, 0);
    chk("midrst_rf1", int'(rf_rdata), 0);

    for (int c = 0; c < 4000; c++) begin
      idle();
      rst        = ($urandom_range(0, 299) == 0);
      layer      = ($urandom_range(0, 4) == 4) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      cu_rst     = ($urandom_range(0, 15) == 0) || (m_acc > 50000) || (m_acc < -50000);
      g_reg_rst7 = ($urandom_range(0, 24) == 0);
      rf_wen     = ($urandom_range(0, 5) == 0);
      rf_ren     = ($urandom_range(0, 1) == 1);
      rf_waddr   = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      rf_raddr   = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      wmem_data  = 1'($urandom_range(0, 1));
      dmem_data  = 9'($urandom_range(0, 511));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
